// File: rtl/compact_op_queue_pkg.sv
// Shared types and default sizing for the compacting multi-lane op queue.
package compact_op_queue_pkg;

    localparam int DEF_WIDTH     = 57;
    localparam int DEF_IN_LANES  = 4;
    localparam int DEF_OUT_LANES = 4;
    localparam int DEF_DEPTH     = 16;

    typedef logic [DEF_WIDTH-1:0] op_t;

endpackage

// File: rtl/compact_op_queue_lane_compactor.sv
// Packs the valid input lanes into the low slots in ascending lane order
// and reports how many were packed.
module lane_compactor
    import compact_op_queue_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IN_LANES = DEF_IN_LANES
) (
    input  logic [IN_LANES*WIDTH-1:0]      i_op,
    input  logic [IN_LANES-1:0]            i_valid,
    output logic [IN_LANES*WIDTH-1:0]      o_packed,
    output logic [$clog2(IN_LANES+1)-1:0]  o_count
);

    localparam int LW = $clog2(IN_LANES + 1);

    logic [IN_LANES*WIDTH-1:0] w_packed;
    logic [LW-1:0]             w_cnt;

    // The running count is both the popcount and the next free packed slot.
    always_comb begin
        w_packed = '0;
        w_cnt    = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            if (i_valid[i]) begin
                w_packed[int'(w_cnt)*WIDTH +: WIDTH] = i_op[i*WIDTH +: WIDTH];
                w_cnt = w_cnt + 1'b1;
            end
        end
    end

    assign o_packed = w_packed;
    assign o_count  = w_cnt;

endmodule

// File: rtl/compact_op_queue.sv
// Circular op queue: compacted multi-lane enqueue at the tail, up to
// OUT_LANES ops presented from the head, partial dequeue and flush.
module compact_op_queue
    import compact_op_queue_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IN_LANES  = DEF_IN_LANES,
    parameter int OUT_LANES = DEF_OUT_LANES,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IN_LANES*WIDTH-1:0]      in_op,
    input  logic [IN_LANES-1:0]            in_valid,
    output logic                           in_ready,
    output logic [OUT_LANES*WIDTH-1:0]     out_op,
    output logic [OUT_LANES-1:0]           out_valid,
    input  logic [$clog2(OUT_LANES+1)-1:0] deq_count,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(IN_LANES + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - IN_LANES);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [PW-1:0]             r_head;
    logic [PW-1:0]             r_tail;
    logic [CW-1:0]             r_count;

    logic [IN_LANES*WIDTH-1:0] w_packed;
    logic [LW-1:0]             w_packed_cnt;
    logic                      w_enq;
    logic [CW-1:0]             w_n_in;
    logic [CW-1:0]             w_deq_ext;
    logic [CW-1:0]             w_n_deq;

    lane_compactor #(
        .WIDTH    (WIDTH),
        .IN_LANES (IN_LANES)
    ) u_compactor (
        .i_op     (in_op),
        .i_valid  (in_valid),
        .o_packed (w_packed),
        .o_count  (w_packed_cnt)
    );

    // Ready looks only at registered occupancy, so a same-cycle dequeue never helps.
    assign in_ready  = (r_count <= READY_MAX);
    assign w_enq     = in_ready && (|in_valid) && !flush;
    assign w_n_in    = w_enq ? CW'(w_packed_cnt) : '0;
    assign w_deq_ext = CW'(deq_count);
    assign w_n_deq   = (w_deq_ext < r_count) ? w_deq_ext : r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_in);
            r_count <= r_count + w_n_in - w_n_deq;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_LANES; k++) begin
            if (k < int'(w_n_in)) begin
                r_mem[r_tail + PW'(k)] <= w_packed[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_op    = '0;
        out_valid = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            out_op[j*WIDTH +: WIDTH] = r_mem[r_head + PW'(j)];
            out_valid[j]             = (int'(r_count) > j);
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_compact_op_queue.sv
// Self-checking bench for compact_op_queue: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_compact_op_queue;
    import compact_op_queue_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int IL = DEF_IN_LANES;
    localparam int OL = DEF_OUT_LANES;
    localparam int D  = DEF_DEPTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IL*W-1:0]   in_op;
    logic [IL-1:0]     in_valid;
    logic              in_ready;
    logic [OL*W-1:0]   out_op;
    logic [OL-1:0]     out_valid;
    logic [2:0]        deq_count;
    logic              flush;
    logic [4:0]        count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] base;
        logic [2:0] deq;
        logic       fl;
        logic [4:0] expCount;
        logic [3:0] expValid;
        logic       expReady;
        logic [7:0] expLane0;
        logic [7:0] expLane1;
    } vec_t;

    vec_t vecs [9];
    op_t  mq [$];

    compact_op_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_op    (out_op),
        .out_valid (out_valid),
        .deq_count (deq_count),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic op_t lane(input int j);
        return out_op[j*W +: W];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setOps(input logic [7:0] base);
        for (int i = 0; i < IL; i++) in_op[i*W +: W] = W'(base) + W'(i);
    endtask

    // Drive one cycle of inputs just after an edge, then advance past the next edge.
    task automatic applyStimulus(input logic [3:0] vld, input logic [7:0] base,
                                 input logic [2:0] deq, input logic fl);
        in_valid  = vld;
        setOps(base);
        deq_count = deq;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_op     = '0;
        deq_count = '0;
        flush     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'b1010, 8'hA0, 3'd0, 1'b0, 5'd2, 4'b0011, 1'b1, 8'hA1, 8'hA3};
        vecs[1] = '{4'b0111, 8'hB0, 3'd0, 1'b0, 5'd5, 4'b1111, 1'b1, 8'hA1, 8'hA3};
        vecs[2] = '{4'b1011, 8'hC0, 3'd2, 1'b0, 5'd6, 4'b1111, 1'b1, 8'hB0, 8'hB1};
        vecs[3] = '{4'b0001, 8'hD0, 3'd0, 1'b0, 5'd7, 4'b1111, 1'b1, 8'hB0, 8'hB1};
        vecs[4] = '{4'b1111, 8'h90, 3'd3, 1'b1, 5'd0, 4'b0000, 1'b1, 8'h00, 8'h00};
        vecs[5] = '{4'b0011, 8'hE0, 3'd0, 1'b0, 5'd2, 4'b0011, 1'b1, 8'hE0, 8'hE1};
        vecs[6] = '{4'b0000, 8'h00, 3'd4, 1'b0, 5'd0, 4'b0000, 1'b1, 8'h00, 8'h00};
        vecs[7] = '{4'b0100, 8'hF0, 3'd0, 1'b0, 5'd1, 4'b0001, 1'b1, 8'hF2, 8'h00};
        vecs[8] = '{4'b0000, 8'h00, 3'd1, 1'b0, 5'd0, 4'b0000, 1'b1, 8'h00, 8'h00};

        doReset();
        checkOutput("reset count", 64'(count), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].vld, vecs[v].base, vecs[v].deq, vecs[v].fl);
            checkOutput($sformatf("vec%0d count", v), 64'(count), 64'(vecs[v].expCount));
            checkOutput($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d in_ready", v), 64'(in_ready), 64'(vecs[v].expReady));
            if (vecs[v].expValid[0])
                checkOutput($sformatf("vec%0d lane0", v), 64'(lane(0)), 64'(vecs[v].expLane0));
            if (vecs[v].expValid[1])
                checkOutput($sformatf("vec%0d lane1", v), 64'(lane(1)), 64'(vecs[v].expLane1));
        end

        // Near-full: ready drops at 13 and a same-cycle dequeue does not raise it.
        doReset();
        applyStimulus(4'b1111, 8'h10, 3'd0, 1'b0);
        applyStimulus(4'b1111, 8'h20, 3'd0, 1'b0);
        applyStimulus(4'b1111, 8'h30, 3'd0, 1'b0);
        applyStimulus(4'b0001, 8'h40, 3'd0, 1'b0);
        checkOutput("full count13", 64'(count), 64'd13);
        checkOutput("full ready low", 64'(in_ready), 64'd0);
        applyStimulus(4'b1111, 8'h50, 3'd0, 1'b0);
        checkOutput("full ignored count", 64'(count), 64'd13);
        checkOutput("full ignored head", 64'(lane(0)), 64'h10);
        in_valid  = 4'b1111;
        setOps(8'h60);
        deq_count = 3'd1;
        #1;
        checkOutput("full ready same cycle", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("full deq count12", 64'(count), 64'd12);
        checkOutput("full ready rises", 64'(in_ready), 64'd1);
        checkOutput("full deq head", 64'(lane(0)), 64'h11);

        // Wrap: park head and tail at 14, then enqueue four ops across the boundary.
        doReset();
        applyStimulus(4'b1111, 8'h10, 3'd0, 1'b0);
        applyStimulus(4'b1111, 8'h20, 3'd0, 1'b0);
        applyStimulus(4'b1111, 8'h30, 3'd0, 1'b0);
        applyStimulus(4'b0011, 8'h40, 3'd0, 1'b0);
        applyStimulus(4'b0000, 8'h00, 3'd4, 1'b0);
        applyStimulus(4'b0000, 8'h00, 3'd4, 1'b0);
        applyStimulus(4'b0000, 8'h00, 3'd4, 1'b0);
        applyStimulus(4'b0000, 8'h00, 3'd2, 1'b0);
        checkOutput("wrap drained", 64'(count), 64'd0);
        applyStimulus(4'b1111, 8'h70, 3'd0, 1'b0);
        checkOutput("wrap count", 64'(count), 64'd4);
        checkOutput("wrap out_valid", 64'(out_valid), 64'hF);
        for (int j = 0; j < 4; j++)
            checkOutput($sformatf("wrap lane%0d", j), 64'(lane(j)), 64'h70 + 64'(j));

        // Randomized traffic against a plain FIFO model.
        doReset();
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] vld;
            logic [2:0] deq;
            logic       fl;
            logic       rs;
            int         nOld;
            int         nDeq;
            logic [3:0] expV;
            vld = 4'($urandom);
            deq = (c < 300) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            fl  = ($urandom_range(0, 31) == 0);
            rs  = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < IL; i++) in_op[i*W +: W] = W'({$urandom, $urandom});
            in_valid  = vld;
            deq_count = deq;
            flush     = fl;
            rst_n     = !rs;

            nOld = mq.size();
            expV = '0;
            for (int j = 0; j < OL; j++) expV[j] = (j < nOld);
            checkOutput("rnd count", 64'(count), 64'(nOld));
            checkOutput("rnd in_ready", 64'(in_ready), 64'(nOld <= D - IL));
            checkOutput("rnd out_valid", 64'(out_valid), 64'(expV));
            for (int j = 0; j < OL && j < nOld; j++)
                checkOutput($sformatf("rnd lane%0d", j), 64'(lane(j)), 64'(mq[j]));

            if (rs || fl) begin
                mq.delete();
            end else begin
                if (nOld <= D - IL) begin
                    for (int i = 0; i < IL; i++)
                        if (vld[i]) mq.push_back(in_op[i*W +: W]);
                end
                nDeq = (int'(deq) < nOld) ? int'(deq) : nOld;
                repeat (nDeq) void'(mq.pop_front());
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/compact_op_queue.md
COMPACT_OP_QUEUE -- requirements
Module: compact_op_queue

Interface
REQ-001 The module SHALL have parameter WIDTH, default 57, meaning bits per operation.
REQ-002 The module SHALL have parameter IN_LANES, default 4, meaning operations offered per cycle.
REQ-003 The module SHALL have parameter OUT_LANES, default 4, meaning operations presented per cycle.
REQ-004 The module SHALL have parameter DEPTH, default 16, meaning queue entries; power of two and >= max(IN_LANES, OUT_LANES).
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 The module SHALL have port in_op, input, IN_LANES*WIDTH, lane i at bits [i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port in_valid, input, IN_LANES, per-lane valid; any pattern, holes allowed.
REQ-009 The module SHALL have port in_ready, output, 1, high when free entries >= IN_LANES.
REQ-010 The module SHALL have port out_op, output, OUT_LANES*WIDTH, oldest entries, lane 0 = head.
REQ-011 The module SHALL have port out_valid, output, OUT_LANES, thermometer: bit j high iff count > j.
REQ-012 The module SHALL have port deq_count, input, clog2(OUT_LANES+1), number of head entries consumed this cycle.
REQ-013 The module SHALL have port flush, input, 1, discard all contents.
REQ-014 The module SHALL have port count, output, clog2(DEPTH+1), current occupancy.

Function
REQ-015 Enqueue SHALL occur when in_ready is high and in_valid is nonzero; n_in = popcount(in_valid).
REQ-016 Valid lanes SHALL be compacted in ascending lane order and written to consecutive entries starting at the tail, with wrap-around modulo DEPTH.
REQ-017 Invalid lanes SHALL never be written and SHALL NOT consume entries.
REQ-018 When in_ready is low, in_op and in_valid SHALL be ignored; the producer holds them.
REQ-019 in_ready SHALL be computed from the registered count only; same-cycle dequeue SHALL NOT raise it.
REQ-020 An enqueued operation SHALL appear on out_op/out_valid one cycle after the enqueue edge; no same-cycle bypass.
REQ-021 out_op lane j SHALL equal entry (head+j) mod DEPTH; lanes with out_valid[j] low are don't-care.
REQ-022 Dequeue SHALL advance head by n_deq = min(deq_count, count) at the clock edge.
REQ-023 Simultaneous enqueue and dequeue SHALL yield count_next = count + n_in - n_deq.
REQ-024 flush SHALL take priority over enqueue and dequeue: next cycle head = tail = 0, count = 0.
REQ-025 deq_count > count SHALL be a protocol violation, clamped per REQ-022, with no corruption.
REQ-026 Pointers SHALL be clog2(DEPTH) bits and wrap naturally; full/empty SHALL be derived from count, not pointer compare.

Reset
REQ-027 While rst_n is low at a rising clk edge, head, tail and count SHALL become 0.
REQ-028 After reset out_valid SHALL be all zero, count 0, in_ready 1.
REQ-029 Reset mid-operation SHALL discard all contents identically to flush; storage array need not be cleared.

Structure
REQ-030 A shared package SHALL hold the operation typedef (WIDTH-bit op_t) and the default lane/depth constants.
REQ-031 One sub-module, lane_compactor, SHALL be purely combinational: IN_LANES ops+valids in, packed ops plus popcount out.
REQ-032 Storage SHALL be a flat register array; no memory macro.

Verification
REQ-033 Reset then in_valid=4'b1010, ops B,D -> next cycle count=2, out_valid=4'b0011, out lane0=B, lane1=D.
REQ-034 Fill to count=13 (DEPTH 16) -> in_ready=0; offered ops ignored; deq_count=1 with count=13 -> in_ready stays 0 that cycle, rises next cycle (count=12).
REQ-035 Head=14, tail=14, enqueue 4 ops W,X,Y,Z -> entries 14,15,0,1; out lanes 0..3 = W,X,Y,Z next cycle.
REQ-036 count=5, enqueue 3 and deq_count=2 same cycle -> count=6, head advanced by 2, order preserved.
REQ-037 count=7, flush with in_valid=4'b1111 and deq_count=3 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-038 count=2, deq_count=4 -> count=0, head advanced by 2; subsequent enqueue of 1 op reads back correctly.
